// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: the per-entry record, the default-depth tag
// type and the entry value loaded on reset.
package rob_pkg;

  localparam int ROB_RD_W      = 5;
  localparam int ROB_VALUE_W   = 64;
  localparam int ROB_DEPTH_DEF = 8;

  typedef logic [$clog2(ROB_DEPTH_DEF)-1:0] rob_tag_t;

  typedef struct packed {
    logic                   valid;
    logic                   done;
    logic                   has_rd;
    logic [ROB_RD_W-1:0]    rd;
    logic [ROB_VALUE_W-1:0] value;
    logic                   mispredict;
  } rob_entry_t;

  localparam rob_entry_t ROB_ENTRY_RST = '0;

endpackage

// File: rtl/rob_commit_select.sv
// Picks the contiguous run of committable entries at the head of the buffer,
// ending the run after the first mispredicted branch, and forms the lanes.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2
) (
  input  rob_entry_t [COMMIT_WIDTH-1:0]                  window,
  output logic       [COMMIT_WIDTH-1:0]                  mask,
  output logic       [COMMIT_WIDTH-1:0]                  lane_has_rd,
  output logic       [COMMIT_WIDTH-1:0][ROB_RD_W-1:0]    lane_rd,
  output logic       [COMMIT_WIDTH-1:0][ROB_VALUE_W-1:0] lane_value,
  output logic                                           flush
);

  logic run;

  always_comb begin
    run         = 1'b1;
    mask        = '0;
    lane_has_rd = '0;
    lane_rd     = '0;
    lane_value  = '0;
    flush       = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (run && window[k].valid && window[k].done) begin
        mask[k]        = 1'b1;
        lane_has_rd[k] = window[k].has_rd;
        lane_rd[k]     = window[k].rd;
        lane_value[k]  = window[k].value;
        // Nothing younger than a mispredicted branch may retire.
        if (window[k].mispredict) begin
          flush = 1'b1;
          run   = 1'b0;
        end
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates in program order, takes writebacks
// out of order, commits up to COMMIT_WIDTH per cycle and flushes on mispredict.
// Define ROB_BYPASS_EN to let a same-cycle writeback commit immediately.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 8,
  parameter int MULTI_ISSUE  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int WB_PORTS     = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [MULTI_ISSUE-1:0]                         alloc_req_i,
  input  logic [MULTI_ISSUE-1:0]                         alloc_has_rd_i,
  input  logic [MULTI_ISSUE-1:0][4:0]                    alloc_rd_i,
  output logic [$clog2(MULTI_ISSUE):0]                   alloc_cnt_o,
  output logic [MULTI_ISSUE-1:0][$clog2(DEPTH)-1:0]      alloc_tag_o,
  input  logic [WB_PORTS-1:0]                            wb_valid_i,
  input  logic [WB_PORTS-1:0][$clog2(DEPTH)-1:0]         wb_tag_i,
  input  logic [WB_PORTS-1:0][DATA_WIDTH-1:0]            wb_value_i,
  input  logic [WB_PORTS-1:0]                            wb_mispredict_i,
  output logic [COMMIT_WIDTH-1:0]                        commit_valid_o,
  output logic [COMMIT_WIDTH-1:0]                        commit_has_rd_o,
  output logic [COMMIT_WIDTH-1:0][4:0]                   commit_rd_o,
  output logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]        commit_value_o,
  output logic                                           flush_o,
  output logic [$clog2(DEPTH):0]                         count_o,
  output logic                                           empty_o
);

  localparam int TAG_W  = $clog2(DEPTH);
  localparam int CNT_W  = TAG_W + 1;
  localparam int ACNT_W = $clog2(MULTI_ISSUE) + 1;

  rob_entry_t entries     [DEPTH];
  rob_entry_t entries_nxt [DEPTH];

  logic [TAG_W-1:0] head, head_nxt;
  logic [TAG_W-1:0] tail, tail_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] ncommit;

  logic [DEPTH-1:0]                  wb_ok;
  logic [DEPTH-1:0][ROB_VALUE_W-1:0] wb_val;
  logic [DEPTH-1:0]                  wb_mp;

  rob_entry_t [COMMIT_WIDTH-1:0]                  window;
  logic       [COMMIT_WIDTH-1:0]                  commit_mask;
  logic       [COMMIT_WIDTH-1:0]                  lane_has_rd;
  logic       [COMMIT_WIDTH-1:0][ROB_RD_W-1:0]    lane_rd;
  logic       [COMMIT_WIDTH-1:0][ROB_VALUE_W-1:0] lane_value;
  logic                                           commit_flush;

  logic [MULTI_ISSUE-1:0] accept;
  logic [ACNT_W-1:0]      acnt;
  logic                   alloc_run;

  // Writeback resolution per entry; ports are scanned high to low so the
  // lowest-indexed port naming a tag is the one that lands.
  always_comb begin
    wb_ok  = '0;
    wb_val = '0;
    wb_mp  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && wb_tag_i[p] == TAG_W'(j)) begin
          wb_ok[j]  = entries[j].valid && !entries[j].done;
          wb_val[j] = ROB_VALUE_W'(wb_value_i[p]);
          wb_mp[j]  = wb_mispredict_i[p];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      window[k] = entries[head + TAG_W'(k)];
`ifdef ROB_BYPASS_EN
      if (wb_ok[head + TAG_W'(k)]) begin
        window[k].done       = 1'b1;
        window[k].value      = wb_val[head + TAG_W'(k)];
        window[k].mispredict = wb_mp[head + TAG_W'(k)];
      end
`endif
    end
  end

  rob_commit_select #(
    .COMMIT_WIDTH(COMMIT_WIDTH)
  ) u_commit_select (
    .window      (window),
    .mask        (commit_mask),
    .lane_has_rd (lane_has_rd),
    .lane_rd     (lane_rd),
    .lane_value  (lane_value),
    .flush       (commit_flush)
  );

  always_comb begin
    ncommit = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      ncommit = ncommit + CNT_W'(commit_mask[k]);
    end
  end

  // Allocation sees only the registered occupancy, never this cycle's frees.
  assign free_slots = CNT_W'(DEPTH) - count;

  always_comb begin
    alloc_run = !rst && !commit_flush;
    accept    = '0;
    acnt      = '0;
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      if (alloc_run && alloc_req_i[i] && (i < int'(free_slots))) begin
        accept[i] = 1'b1;
        acnt      = acnt + ACNT_W'(1);
      end else begin
        alloc_run = 1'b0;
      end
    end
  end

  always_comb begin
    entries_nxt = entries;
    for (int j = 0; j < DEPTH; j++) begin
      if (wb_ok[j] && !commit_flush) begin
        entries_nxt[j].done       = 1'b1;
        entries_nxt[j].value      = wb_val[j];
        entries_nxt[j].mispredict = wb_mp[j];
      end
    end
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      if (accept[i]) begin
        entries_nxt[tail + TAG_W'(i)].valid      = 1'b1;
        entries_nxt[tail + TAG_W'(i)].done       = 1'b0;
        entries_nxt[tail + TAG_W'(i)].has_rd     = alloc_has_rd_i[i];
        entries_nxt[tail + TAG_W'(i)].rd         = alloc_rd_i[i];
        entries_nxt[tail + TAG_W'(i)].mispredict = 1'b0;
      end
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_mask[k]) begin
        entries_nxt[head + TAG_W'(k)].valid = 1'b0;
        entries_nxt[head + TAG_W'(k)].done  = 1'b0;
      end
    end
    if (commit_flush) begin
      for (int j = 0; j < DEPTH; j++) begin
        entries_nxt[j].valid = 1'b0;
        entries_nxt[j].done  = 1'b0;
      end
    end
    head_nxt  = head + TAG_W'(ncommit);
    tail_nxt  = commit_flush ? head_nxt : tail + TAG_W'(acnt);
    count_nxt = commit_flush ? '0 : count + CNT_W'(acnt) - ncommit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        entries[j] <= ROB_ENTRY_RST;
      end
    end else begin
      head    <= head_nxt;
      tail    <= tail_nxt;
      count   <= count_nxt;
      entries <= entries_nxt;
    end
  end

  always_comb begin
    alloc_cnt_o     = acnt;
    commit_valid_o  = '0;
    commit_has_rd_o = '0;
    commit_rd_o     = '0;
    commit_value_o  = '0;
    flush_o         = 1'b0;
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      alloc_tag_o[i] = rst ? '0 : tail + TAG_W'(i);
    end
    if (!rst) begin
      commit_valid_o  = commit_mask;
      commit_has_rd_o = lane_has_rd;
      commit_rd_o     = lane_rd;
      flush_o         = commit_flush;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        commit_value_o[k] = lane_value[k][DATA_WIDTH-1:0];
      end
    end
  end

  assign count_o = count;
  assign empty_o = (count == '0);

endmodule
